// File: rtl/fetch_controller_if.sv
// Bundles the instruction-memory port and the decode-side valid/ready handshake
// of the fetch controller. The controller takes the master modport.
interface fetch_controller_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output if_valid,
        output if_instr,
        output if_pc,
        input  id_ready
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output id_ready
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, tracks one in-flight read and buffers returns
// in a 2-entry skid FIFO for decode. Optional perf counters under `define FETCH_PERF_EN.
module fetch_controller #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                halt_req,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    fetch_controller_if.master  bus,
    output logic                busy,
    output logic [31:0]         perf_fetches,
    output logic [31:0]         perf_stalls
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

    localparam logic [XLEN-1:0] STEP = XLEN'(4);

    state_e          state_q;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic            infl_q, infl_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] e0_instr_q, e0_instr_d, e0_pc_q, e0_pc_d;
    logic [XLEN-1:0] e1_instr_q, e1_instr_d, e1_pc_q, e1_pc_d;

    logic            run, redir, pop, push, issue;
    logic [1:0]      cnt_pop;
    logic [XLEN-1:0] tgt;
    logic            unused_rpc_lsb;

    assign run     = (state_q == S_RUN);
    assign redir   = run & redirect_valid;
    assign pop     = bus.if_valid & bus.id_ready;
    // A redirect squashes the word returning this cycle.
    assign push    = infl_q & ~redir;
    assign cnt_pop = cnt_q - {1'b0, pop};
    assign issue   = run & ~halt_req & ~redir & ((cnt_pop + {1'b0, infl_q}) < 2'd2);
    assign tgt     = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_rpc_lsb = ^redirect_pc[1:0];

    always_comb begin
        pc_d       = pc_q;
        addr_d     = addr_q;
        ipc_d      = ipc_q;
        infl_d     = 1'b0;
        cnt_d      = cnt_pop;
        e0_instr_d = e0_instr_q;
        e0_pc_d    = e0_pc_q;
        e1_instr_d = e1_instr_q;
        e1_pc_d    = e1_pc_q;

        if (pop) begin
            e0_instr_d = e1_instr_q;
            e0_pc_d    = e1_pc_q;
        end
        if (push) begin
            if (cnt_pop == 2'd0) begin
                e0_instr_d = bus.imem_rdata;
                e0_pc_d    = ipc_q;
            end else begin
                e1_instr_d = bus.imem_rdata;
                e1_pc_d    = ipc_q;
            end
            cnt_d = cnt_pop + 2'd1;
        end

        if (redirect_valid && !run) begin
            pc_d = tgt;
        end else if (redir) begin
            cnt_d = 2'd0;
            pc_d  = tgt;
            // Halting in the same cycle parks the PC on the target without fetching it.
            if (!halt_req) begin
                addr_d = tgt;
                ipc_d  = tgt;
                pc_d   = tgt + STEP;
                infl_d = 1'b1;
            end
        end else if (issue) begin
            addr_d = pc_q;
            ipc_d  = pc_q;
            pc_d   = pc_q + STEP;
            infl_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_q <= S_RUN;
                S_RUN:   if (halt_req) state_q <= S_HALT;
                S_HALT:  if (start && !halt_req) state_q <= S_RUN;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            ipc_q      <= '0;
            infl_q     <= 1'b0;
            cnt_q      <= 2'd0;
            e0_instr_q <= '0;
            e0_pc_q    <= '0;
            e1_instr_q <= '0;
            e1_pc_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            ipc_q      <= ipc_d;
            infl_q     <= infl_d;
            cnt_q      <= cnt_d;
            e0_instr_q <= e0_instr_d;
            e0_pc_q    <= e0_pc_d;
            e1_instr_q <= e1_instr_d;
            e1_pc_q    <= e1_pc_d;
        end
    end

    assign bus.imem_addr = addr_q;
    assign bus.if_valid  = (cnt_q != 2'd0);
    assign bus.if_instr  = e0_instr_q;
    assign bus.if_pc     = e0_pc_q;
    assign busy          = run | infl_q | (cnt_q != 2'd0);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_f_q, perf_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_f_q <= '0;
            perf_s_q <= '0;
        end else begin
            if (infl_d) perf_f_q <= perf_f_q + 32'd1;
            if (bus.if_valid && !bus.id_ready) perf_s_q <= perf_s_q + 32'd1;
        end
    end

    assign perf_fetches = perf_f_q;
    assign perf_stalls  = perf_s_q;
`else
    assign perf_fetches = 32'h0;
    assign perf_stalls  = 32'h0;
`endif
endmodule
